fifo_rd_stream: RTL and testbench

Read-side adapter that drains a standard-mode (non-FWFT) synchronous FIFO with one-cycle read latency and presents its contents as a valid/ready stream to the downstream consumer. It sits directly after the FIFO. It issues `fifo_rd_en` only when output space is guaranteed for the in-flight word, and it sustains one beat per cycle under continuous `m_ready`. It also flags protocol errors on the FIFO read side.

---
 rtl/fifo_rd_stream_pkg.sv | 36 +++
 rtl/frs_skid_buf2.sv | 72 +++++++
 rtl/fifo_rd_stream.sv | 129 ++++++++++++
 tb/tb_fifo_rd_stream.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg
// Shared constants for the FIFO read-side stream adapter:
//   FRS_BUF_DEPTH / FRS_PTR_W / FRS_CNT_W : geometry of the 2-entry output buffer
//   FRS_ERR_*                             : bit positions of the protocol error causes
//   frs_err_causes()                      : decodes the per-cycle error causes
package fifo_rd_stream_pkg;

  localparam int FRS_BUF_DEPTH = 2;
  localparam int FRS_PTR_W     = 1;
  localparam int FRS_CNT_W     = 2;   // holds occupancy 0..2 and slots 0..3

  // Error-cause encodings (bit positions in the cause vector)
  localparam int FRS_ERR_UNEXP = 0;   // read data with no read in flight
  localparam int FRS_ERR_OVFL  = 1;   // read data while buffer full and not draining
  localparam int FRS_ERR_UNDFL = 2;   // FIFO reported underflow
  localparam int FRS_ERR_W     = 3;

  // Decode which protocol errors occur this cycle. ignore_valid masks a
  // stale word returning in the first cycle after reset.
  function automatic logic [FRS_ERR_W-1:0] frs_err_causes(
    input logic valid,
    input logic inflight,
    input logic full,
    input logic pop,
    input logic underflow,
    input logic ignore_valid
  );
    logic [FRS_ERR_W-1:0] c;
    c                = {FRS_ERR_W{1'b0}};
    c[FRS_ERR_UNEXP] = valid & ~ignore_valid & ~inflight;
    c[FRS_ERR_OVFL]  = valid & ~ignore_valid & inflight & full & ~pop;
    c[FRS_ERR_UNDFL] = underflow;
    return c;
  endfunction

endpackage

// File: rtl/frs_skid_buf2.sv
// frs_skid_buf2
// Two-entry in-order buffer with 1-bit head/tail pointers and occupancy count.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   push     : write din at tail (ignored when full and not popping)
//   pop      : retire head entry (ignored when empty)
//   din      : write data
//   dout     : head entry, read straight from the storage registers
//   cnt      : occupancy 0..2
module frs_skid_buf2
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [FRS_CNT_W-1:0]  cnt
);

  logic [DATA_WIDTH-1:0] mem_r [FRS_BUF_DEPTH];
  logic [FRS_PTR_W-1:0]  head_r;
  logic [FRS_PTR_W-1:0]  tail_r;
  logic [FRS_CNT_W-1:0]  cnt_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  // Qualify requests so the storage can never over- or under-run.
  always_comb begin
    pop_ok_s  = pop & (cnt_r != 2'd0);
    push_ok_s = push & ((cnt_r != 2'd2) | pop_ok_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FRS_BUF_DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
      head_r <= {FRS_PTR_W{1'b0}};
      tail_r <= {FRS_PTR_W{1'b0}};
      cnt_r  <= 2'd0;
    end else begin
      if (push_ok_s) begin
        mem_r[tail_r] <= din;
        tail_r        <= tail_r + 1'b1;
      end else begin
        tail_r <= tail_r;
      end
      if (pop_ok_s) begin
        head_r <= head_r + 1'b1;
      end else begin
        head_r <= head_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;   // idle, or push+pop together
      endcase
    end
  end

  // Head entry drives the output directly from a storage register.
  always_comb begin
    dout = mem_r[head_r];
    cnt  = cnt_r;
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
// Drains a standard-mode (1-cycle read latency) synchronous FIFO into a
// valid/ready stream. A read is issued only when the 2-entry output buffer is
// guaranteed room for the returning word, giving 1 beat/cycle when m_ready
// stays high. Protocol violations on the FIFO side set a sticky err.
// Optional feature: define FIFO_RD_STREAM_LAST_EN to mark every BURST_LEN-th
// beat with m_last; otherwise m_last is tied low.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   fifo_empty            : FIFO empty flag
//   fifo_rd_en            : FIFO read request (combinational)
//   fifo_dout, fifo_valid : FIFO read data and its valid (1 cycle after read)
//   fifo_underflow        : FIFO underflow pulse
//   m_valid, m_ready      : stream handshake
//   m_data, m_last        : stream data, last beat of a BURST_LEN group
//   err                   : sticky protocol error
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_valid,
  input  logic                  fifo_underflow,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  err
);

  if (BURST_LEN < 1) begin : g_bad_burst_len
    $error("fifo_rd_stream: BURST_LEN must be >= 1");
  end

  logic [FRS_CNT_W-1:0] buf_cnt_s;
  logic [FRS_CNT_W-1:0] slots_s;
  logic                 inflight_r;
  logic                 post_rst_r;
  logic                 err_r;
  logic                 pop_s;
  logic                 push_s;
  logic                 full_s;
  logic [FRS_ERR_W-1:0] cause_s;

  // Handshake, read issue and push qualification.
  always_comb begin
    m_valid = (buf_cnt_s != 2'd0);
    pop_s   = m_valid & m_ready;
    full_s  = (buf_cnt_s == 2'd2);
    slots_s = buf_cnt_s + {1'b0, inflight_r};
    // A pop this cycle frees the slot the new word will need next cycle.
    fifo_rd_en = ~fifo_empty & ~rst &
                 ((slots_s < 2'd2) | ((slots_s == 2'd2) & pop_s));
    // A word with nowhere to go is dropped; a stale post-reset word too.
    push_s  = fifo_valid & ~post_rst_r & (~full_s | pop_s);
    cause_s = frs_err_causes(fifo_valid, inflight_r, full_s, pop_s,
                             fifo_underflow, post_rst_r);
    err     = err_r;
  end

  // Read-in-flight tracking and first-cycle-after-reset marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_r <= 1'b0;
      post_rst_r <= 1'b1;
    end else begin
      inflight_r <= fifo_rd_en;
      post_rst_r <= 1'b0;
    end
  end

  // Sticky protocol error.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (|cause_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  frs_skid_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .push (push_s),
    .pop  (pop_s),
    .din  (fifo_dout),
    .dout (m_data),
    .cnt  (buf_cnt_s)
  );

`ifdef FIFO_RD_STREAM_LAST_EN
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

  logic [BEAT_W-1:0] beat_r;

  // Last beat of a group is flagged from the pop counter.
  always_comb begin
    m_last = m_valid & (beat_r == BEAT_MAX);
  end

  // Count accepted beats, wrapping after the last beat of each group.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_r <= {BEAT_W{1'b0}};
    end else if (pop_s) begin
      beat_r <= m_last ? {BEAT_W{1'b0}} : beat_r + BEAT_W'(1);
    end else begin
      beat_r <= beat_r;
    end
  end
`else
  // No grouping: m_last kept only so the port list is build-independent.
  always_comb begin
    m_last = 1'b0;
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: a 1-cycle-latency FIFO environment,
// a queue-based reference model compared every cycle, directed scenarios with
// literal expectations, and a randomized soak.
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int BL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, fifo_empty, fifo_rd_en, fifo_valid, fifo_underflow;
  logic          m_valid, m_ready, m_last, err;
  logic [DW-1:0] fifo_dout, m_data;

  fifo_rd_stream #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .fifo_valid(fifo_valid), .fifo_underflow(fifo_underflow),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .err(err)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // FIFO environment: contents plus the word returning from last cycle's read
  logic [DW-1:0] fq[$];
  logic          env_v = 1'b0;
  logic [DW-1:0] env_d = '0;

  // Reference model: words held for the consumer, in order
  logic [DW-1:0] mq[$];
  logic          m_infl = 1'b0, m_err = 1'b0, m_post = 1'b0;
  int            m_beats = 0;

  // Observation logs for literal checks
  logic [DW-1:0] pop_d[$];
  int            pop_c[$];
  logic          pop_l[$];
  int            rd_c[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_logs();
    pop_d.delete(); pop_c.delete(); pop_l.delete(); rd_c.delete();
  endtask

  task automatic load(input int n);
    for (int i = 1; i <= n; i++) fq.push_back(DW'(i));
  endtask

  // One clock cycle: drive inputs, compare against the model, advance.
  task automatic cycle(input logic r, input logic rdy, input logic inj_v,
                       input logic [DW-1:0] inj_d, input logic und);
    logic e_valid, e_pop, e_rd, e_last, full, unexp, ovf, rd_seen;
    int slots;
    @(negedge clk);
    rst = r; m_ready = rdy; fifo_underflow = und;
    fifo_empty = (fq.size() == 0);
    fifo_valid = env_v | inj_v;
    fifo_dout  = env_v ? env_d : inj_d;
    #1;
    e_valid = (mq.size() != 0);
    e_pop   = e_valid & rdy;
    slots   = mq.size() + int'(m_infl);
    e_rd    = !fifo_empty && !r && (slots < 2 || (slots == 2 && e_pop));
    e_last  = 1'b0;
`ifdef FIFO_RD_STREAM_LAST_EN
    e_last  = e_valid && ((m_beats % BL) == BL - 1);
`endif
    chk("rd_en", fifo_rd_en, e_rd);
    chk("m_valid", m_valid, e_valid);
    chk("m_last", m_last, e_last);
    chk("err", err, m_err);
    if (e_valid) chk("m_data", m_data, mq[0]);
    if (m_valid && rdy) begin
      pop_d.push_back(m_data); pop_c.push_back(cyc); pop_l.push_back(m_last);
    end
    if (fifo_rd_en) rd_c.push_back(cyc);
    rd_seen = fifo_rd_en;
    if (r) begin
      mq.delete(); m_infl = 1'b0; m_err = 1'b0; m_beats = 0; m_post = 1'b1;
    end else begin
      full  = (mq.size() == 2);
      unexp = fifo_valid && !m_post && !m_infl;
      ovf   = fifo_valid && !m_post && m_infl && full && !e_pop;
      if (unexp || ovf || und) m_err = 1'b1;
      if (e_pop) begin void'(mq.pop_front()); m_beats++; end
      if (fifo_valid && !m_post && (!full || e_pop)) mq.push_back(fifo_dout);
      m_infl = e_rd;
      m_post = 1'b0;
    end
    @(posedge clk);
    env_v = 1'b0;
    if (rd_seen && fq.size() != 0) begin
      env_d = fq.pop_front();
      env_v = 1'b1;
    end
    cyc++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, rdy, 1'b0, '0, 1'b0);
  endtask

  initial begin
    int n0;
    logic rr;
    rst = 1'b1; m_ready = 1'b0; fifo_empty = 1'b1; fifo_valid = 1'b0;
    fifo_underflow = 1'b0; fifo_dout = '0;
    @(posedge clk);

    // Reset state, with a non-empty FIFO that must not be read during reset
    load(8);
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
    #1;
    chk("rst_m_data", m_data, 8'h00);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_m_last", m_last, 1'b0);

    // Streaming 0x01..0x08 with m_ready high
    clear_logs();
    idle(14, 1'b1);
    chk("stream_rd_cnt", rd_c.size(), 8);
    chk("stream_pop_cnt", pop_d.size(), 8);
    for (int i = 0; i < 8 && i < rd_c.size() && i < pop_d.size(); i++) begin
      chk("stream_rd_cyc", rd_c[i], rd_c[0] + i);
      chk("stream_data", pop_d[i], DW'(i + 1));
      chk("stream_pop_cyc", pop_c[i], rd_c[0] + 2 + i);
    end
    chk("stream_err", err, 1'b0);

    // Backpressure then restart in the same cycle
    clear_logs();
    load(4);
    idle(5, 1'b0);
    #1;
    chk("bp_rd_cnt", rd_c.size(), 2);
    chk("bp_m_data", m_data, 8'h01);
    chk("bp_m_valid", m_valid, 1'b1);
    n0 = cyc;
    idle(1, 1'b1);
    chk("restart_rd_cnt", rd_c.size(), 3);
    if (rd_c.size() == 3) chk("restart_rd_cyc", rd_c[2], n0);
    idle(6, 1'b1);
    chk("bp_pop_cnt", pop_d.size(), 4);
    for (int i = 0; i < 4 && i < pop_d.size(); i++) begin
      chk("bp_data", pop_d[i], DW'(i + 1));
      chk("bp_pop_cyc", pop_c[i], n0 + i);
    end

    // Unexpected fifo_valid with nothing in flight
    cycle(1'b0, 1'b0, 1'b1, 8'hAA, 1'b0);
    #1;
    chk("unexp_err", err, 1'b1);
    idle(3, 1'b1);
    #1;
    chk("unexp_err_held", err, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    #1;
    chk("rst_clears_err", err, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    #1;
    chk("underflow_err", err, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);

    // Mid-stream reset with a read in flight; stale word after reset dropped
    load(8);
    idle(4, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
    #1;
    chk("midrst_m_valid", m_valid, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 8'h55, 1'b0);
    #1;
    chk("midrst_drop", m_valid, 1'b0);
    chk("midrst_err", err, 1'b0);
    idle(12, 1'b1);

    // m_last grouping over 8 beats with random m_ready
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    clear_logs();
    load(8);
    for (int i = 0; i < 24; i++) idle(1, 1'($urandom_range(0, 1)));
    idle(12, 1'b1);
    chk("last_pop_cnt", pop_l.size(), 8);
    for (int i = 0; i < 8 && i < pop_l.size(); i++) begin
`ifdef FIFO_RD_STREAM_LAST_EN
      chk("last_flag", pop_l[i], (i == 3 || i == 7));
`else
      chk("last_flag", pop_l[i], 1'b0);
`endif
    end

    // Randomized soak against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0 && fq.size() < 6) fq.push_back(DW'($urandom));
      rr = ($urandom_range(0, 79) == 0);
      cycle(rr, 1'($urandom_range(0, 3) != 0), ($urandom_range(0, 149) == 0),
            DW'($urandom), ($urandom_range(0, 299) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
